rbm_vote_controller: RTL and testbench
======================================

RBM_VOTE_CONTROLLER -- requirements
Module: rbm_vote_controller

Interface
REQ-001 SHALL have parameter OUT_DIM, default 10, number of output classes voted on.
REQ-002 SHALL have parameter CNT_W, default 12, width of each vote counter.
REQ-003 SHALL have parameter ITER_W, default 10, width of iteration limit and iteration count.
REQ-004 SHALL have parameter IDX_W, default 4, winner index width (>= clog2(OUT_DIM)).
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  begin a classification run; sampled only in IDLE or DONE.
REQ-008 abort  input  1  terminate the current run and return to IDLE.
REQ-009 iter_limit  input  ITER_W  maximum sampling iterations, latched at start.
REQ-010 margin  input  CNT_W  early-stop lead (top1 minus top2), latched at start.
REQ-011 early_stop_en  input  1  enable margin-based early stop, latched at start.
REQ-012 layer_reset  output  1  restarts the external RBM layer chain for one sample pass.
REQ-013 layer_done  input  1  external chain has a valid one-hot/multi-hot sample.
REQ-014 layer_sample  input  OUT_DIM  binary sample per class, valid while layer_done=1.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  run complete; results stable.
REQ-017 vote_count  output  OUT_DIM*CNT_W  per-class counters, class i at bits [i*CNT_W +: CNT_W].
REQ-018 winner  output  IDX_W  index of class with highest count.
REQ-019 winner_valid  output  1  at least one nonzero count at completion.
REQ-020 iter_count  output  ITER_W  iterations accumulated this run.
REQ-021 early_stopped  output  1  run ended by margin rule, not iter_limit.

Function
REQ-022 SHALL implement states IDLE, LAUNCH, WAIT, ACCUM, SCAN, DONE.
REQ-023 IDLE/DONE + start=1: latch iter_limit, margin, early_stop_en; clear vote_count, iter_count, winner, winner_valid, early_stopped, done; go LAUNCH (or DONE next cycle if iter_limit=0).
REQ-024 LAUNCH: layer_reset=1 for exactly one cycle; next state WAIT.
REQ-025 WAIT: layer_reset=0; stay until layer_done=1; then go ACCUM; layer_done in any other state ignored.
REQ-026 ACCUM (one cycle): for each i with captured layer_sample[i]=1, vote_count[i] += 1, saturating at 2^CNT_W-1; iter_count += 1; sample captured on the WAIT->ACCUM edge.
REQ-027 SCAN: OUT_DIM cycles, one class per cycle from index 0 upward, tracking top1 value/index and top2 value; strict greater-than update so ties resolve to lowest index.
REQ-028 End of SCAN: winner := top1 index; if iter_count = latched iter_limit -> DONE; else if early_stop_en and top1-top2 >= margin and top1 > 0 -> DONE with early_stopped=1; else -> LAUNCH.
REQ-029 Per-iteration latency: 1 (LAUNCH) + W (WAIT, >=1) + 1 (ACCUM) + OUT_DIM (SCAN) cycles.
REQ-030 DONE: done=1, winner_valid = (top1 > 0); all results held until next accepted start or reset.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort=1 in any state SHALL force IDLE next cycle, layer_reset=1 during that cycle, done=0; counters retain last values; abort has priority over start and layer_done.
REQ-033 iter_limit=0: no LAUNCH; DONE one cycle after start with all counts 0, winner=0, winner_valid=0, iter_count=0.
REQ-034 Saturated counters SHALL still take part in SCAN; saturation SHALL not wrap.
REQ-035 margin=0 with early_stop_en=1 SHALL stop after first iteration producing any nonzero count.

Reset
REQ-036 Reset asserted: state IDLE, layer_reset=1, busy=0, done=0, vote_count=0, winner=0, winner_valid=0, iter_count=0, early_stopped=0, latched config=0.
REQ-037 Reset mid-run SHALL discard all progress; first edge after deassert stays IDLE with layer_reset=0.

Verification
REQ-038 iter_limit=5, early_stop_en=0, sample=0b0000001000 every pass -> done, count[3]=5, others 0, winner=3, iter_count=5, early_stopped=0.
REQ-039 iter_limit=100, margin=3, early_stop_en=1, sample class 7 every pass -> done after 3 iterations, winner=7, early_stopped=1.
REQ-040 OUT_DIM=10, CNT_W=2, iter_limit=6, sample all-ones -> every count=3 (saturated), winner=0 (tie low index), winner_valid=1.
REQ-041 iter_limit=0 start -> done one cycle later, winner_valid=0, layer_reset never pulsed.
REQ-042 abort during WAIT of iteration 2 -> IDLE next cycle, busy=0, done=0; subsequent start runs cleanly from zero.
REQ-043 reset asserted during SCAN -> all outputs zero immediately; layer_done pulses in IDLE produce no count change.

Source files
------------

// File: rtl/rbm_vote_controller_if.sv
// Bus between the vote controller and its environment: run control, the
// handshake with the external RBM layer chain, and the vote results.
//
// Layer-chain handshake: the controller pulses layer_reset for one cycle to
// launch a sample pass. The chain answers with layer_done (valid) while
// layer_sample holds the sample. The controller is ready only while waiting
// for a sample, so the first cycle it sees layer_done=1 completes the
// transfer. A layer_done seen at any other time is dropped.
interface rbm_vote_controller_if #(
  parameter int OUT_DIM = 10,
  parameter int CNT_W   = 12,
  parameter int ITER_W  = 10,
  parameter int IDX_W   = 4
);
  logic                     start;
  logic                     abort;
  logic [ITER_W-1:0]        iter_limit;
  logic [CNT_W-1:0]         margin;
  logic                     early_stop_en;
  logic                     layer_reset;
  logic                     layer_done;
  logic [OUT_DIM-1:0]       layer_sample;
  logic                     busy;
  logic                     done;
  logic [OUT_DIM*CNT_W-1:0] vote_count;
  logic [IDX_W-1:0]         winner;
  logic                     winner_valid;
  logic [ITER_W-1:0]        iter_count;
  logic                     early_stopped;

  modport slave (
    input  start, abort, iter_limit, margin, early_stop_en, layer_done, layer_sample,
    output layer_reset, busy, done, vote_count, winner, winner_valid, iter_count,
           early_stopped
  );

  modport master (
    output start, abort, iter_limit, margin, early_stop_en, layer_done, layer_sample,
    input  layer_reset, busy, done, vote_count, winner, winner_valid, iter_count,
           early_stopped
  );
endinterface

// File: rtl/rbm_vote_controller.sv
// rbm_vote_controller: runs repeated RBM sample passes, accumulates a
// saturating vote per class, scans the counters for the leading class and
// stops on the iteration limit or, optionally, once the leader is far enough
// ahead of the runner-up.
module rbm_vote_controller #(
  parameter int OUT_DIM = 10,
  parameter int CNT_W   = 12,
  parameter int ITER_W  = 10,
  parameter int IDX_W   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  rbm_vote_controller_if.slave bus,
  output logic [2:0]           state_o
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ACCUM  = 3'd3,
    S_SCAN   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_DIM - 1);

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q [OUT_DIM];
  logic [OUT_DIM-1:0]       sample_q;
  logic [ITER_W-1:0]        iter_limit_q;
  logic [ITER_W-1:0]        iter_count_q;
  logic [CNT_W-1:0]         margin_q;
  logic                     es_en_q;
  logic [CNT_W-1:0]         top1_q, top2_q;
  logic [IDX_W-1:0]         top1_idx_q, scan_idx_q, winner_q;
  logic                     layer_reset_q, done_q, winner_valid_q, early_stopped_q;

  logic [CNT_W-1:0]         cur_v, top1_d, top2_d;
  logic [IDX_W-1:0]         top1_idx_d;
  logic [OUT_DIM*CNT_W-1:0] vote_flat;

  assign state_o           = state_q;
  assign bus.layer_reset   = layer_reset_q;
  assign bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done          = done_q;
  assign bus.vote_count    = vote_flat;
  assign bus.winner        = winner_q;
  assign bus.winner_valid  = winner_valid_q;
  assign bus.iter_count    = iter_count_q;
  assign bus.early_stopped = early_stopped_q;

  // Pack the per-class counters into the flat result vector.
  always_comb begin
    vote_flat = '0;
    for (int i = 0; i < OUT_DIM; i++) vote_flat[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  // One scan step: strict greater-than keeps the lowest index on ties.
  always_comb begin
    cur_v      = cnt_q[scan_idx_q];
    top1_d     = top1_q;
    top2_d     = top2_q;
    top1_idx_d = top1_idx_q;
    if (cur_v > top1_q) begin
      top2_d     = top1_q;
      top1_d     = cur_v;
      top1_idx_d = scan_idx_q;
    end else if (cur_v > top2_q) begin
      top2_d = cur_v;
    end
  end

  // Run sequencing, vote accumulation and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      for (int i = 0; i < OUT_DIM; i++) cnt_q[i] <= '0;
      sample_q        <= '0;
      iter_limit_q    <= '0;
      iter_count_q    <= '0;
      margin_q        <= '0;
      es_en_q         <= 1'b0;
      top1_q          <= '0;
      top2_q          <= '0;
      top1_idx_q      <= '0;
      scan_idx_q      <= '0;
      winner_q        <= '0;
      layer_reset_q   <= 1'b1;
      done_q          <= 1'b0;
      winner_valid_q  <= 1'b0;
      early_stopped_q <= 1'b0;
    end else if (bus.abort) begin
      // Abort wins over everything; the chain is held in reset for the
      // first idle cycle and the counters keep their partial values.
      state_q       <= S_IDLE;
      layer_reset_q <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          layer_reset_q <= 1'b0;
          if (bus.start) begin
            iter_limit_q    <= bus.iter_limit;
            margin_q        <= bus.margin;
            es_en_q         <= bus.early_stop_en;
            for (int i = 0; i < OUT_DIM; i++) cnt_q[i] <= '0;
            iter_count_q    <= '0;
            winner_q        <= '0;
            winner_valid_q  <= 1'b0;
            early_stopped_q <= 1'b0;
            if (bus.iter_limit == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q       <= S_LAUNCH;
              layer_reset_q <= 1'b1;
              done_q        <= 1'b0;
            end
          end
        end
        S_LAUNCH: begin
          layer_reset_q <= 1'b0;
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.layer_done) begin
            sample_q <= bus.layer_sample;
            state_q  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < OUT_DIM; i++) begin
            if (sample_q[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
          iter_count_q <= iter_count_q + ITER_W'(1);
          top1_q       <= '0;
          top2_q       <= '0;
          top1_idx_q   <= '0;
          scan_idx_q   <= '0;
          state_q      <= S_SCAN;
        end
        S_SCAN: begin
          top1_q     <= top1_d;
          top2_q     <= top2_d;
          top1_idx_q <= top1_idx_d;
          scan_idx_q <= scan_idx_q + IDX_W'(1);
          if (scan_idx_q == LAST_IDX) begin
            winner_q <= top1_idx_d;
            if (iter_count_q == iter_limit_q) begin
              state_q        <= S_DONE;
              done_q         <= 1'b1;
              winner_valid_q <= (top1_d != '0);
            end else if (es_en_q && ((top1_d - top2_d) >= margin_q) && (top1_d != '0)) begin
              state_q         <= S_DONE;
              done_q          <= 1'b1;
              winner_valid_q  <= 1'b1;
              early_stopped_q <= 1'b1;
            end else begin
              state_q       <= S_LAUNCH;
              layer_reset_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q       <= S_IDLE;
          layer_reset_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rbm_vote_controller.sv
// Testbench for rbm_vote_controller: directed and randomized runs checked
// against a reference model that replays the supplied samples with plain
// per-class arithmetic and an argmax over the counters.
module tb_rbm_vote_controller;
  localparam int OUT_DIM = 10;
  localparam int CNT_W   = 12;
  localparam int ITER_W  = 10;
  localparam int IDX_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  // Debug state encoding exported on state_o.
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd2, ST_SCAN = 3'd4, ST_DONE = 3'd5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rbm_vote_controller_if #(.OUT_DIM(OUT_DIM), .CNT_W(CNT_W), .ITER_W(ITER_W), .IDX_W(IDX_W)) bus0 ();
  rbm_vote_controller_if #(.OUT_DIM(OUT_DIM), .CNT_W(2), .ITER_W(ITER_W), .IDX_W(IDX_W)) bus1 ();
  logic [2:0] state0, state1;

  rbm_vote_controller #(.OUT_DIM(OUT_DIM), .CNT_W(CNT_W), .ITER_W(ITER_W), .IDX_W(IDX_W)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave), .state_o(state0));
  rbm_vote_controller #(.OUT_DIM(OUT_DIM), .CNT_W(2), .ITER_W(ITER_W), .IDX_W(IDX_W)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave), .state_o(state1));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0]   exp_q[$];
  logic [OUT_DIM-1:0] samp_q[$];
  int                 wait_q[$];
  int                 mode = 0;
  int                 fixed_d = 0;
  logic [OUT_DIM-1:0] pat = '0;
  bit                 kick = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- driver: external layer chain for dut0 ----------------
  initial begin
    int d;
    logic [OUT_DIM-1:0] smp;
    bus0.layer_done   = 1'b0;
    bus0.layer_sample = '0;
    forever begin
      @(negedge clock);
      if ((bus0.layer_reset && bus0.busy) || kick) begin
        d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 4));
        case (mode)
          1:       smp = OUT_DIM'($urandom & $urandom);
          2:       smp = (samp_q.size() == 0) ? '0 : pat;
          default: smp = pat;
        endcase
        repeat (d) @(negedge clock);
        bus0.layer_sample = smp;
        bus0.layer_done   = 1'b1;
        samp_q.push_back(smp);
        wait_q.push_back(d);
        @(negedge clock);
        bus0.layer_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_state(input string tag);
    check({tag, "_layer_reset"}, bus0.layer_reset, 1);
    check({tag, "_busy"}, bus0.busy, 0);
    check({tag, "_done"}, bus0.done, 0);
    check({tag, "_vote_count"}, bus0.vote_count, 0);
    check({tag, "_winner"}, bus0.winner, 0);
    check({tag, "_winner_valid"}, bus0.winner_valid, 0);
    check({tag, "_iter_count"}, bus0.iter_count, 0);
    check({tag, "_early_stopped"}, bus0.early_stopped, 0);
    check({tag, "_state"}, state0, ST_IDLE);
  endtask

  // Start one run on dut0, let the chain driver answer, then compare all
  // results with the model replaying the samples the driver handed out.
  task automatic run0(input int limit, input int mg, input bit es, input int md,
                      input bit poke, input string tag);
    int cyc, lr, n_it, win, t1, t2, exp_cyc;
    bit stopped, es_hit;
    int cnt[OUT_DIM];
    logic [OUT_DIM-1:0] s;
    samp_q.delete();
    wait_q.delete();
    mode = md;
    @(negedge clock);
    bus0.iter_limit    = ITER_W'(limit);
    bus0.margin        = CNT_W'(mg);
    bus0.early_stop_en = es;
    bus0.start         = 1'b1;
    @(negedge clock);
    bus0.start = 1'b0;
    cyc = 1;
    lr  = 0;
    forever begin
      if (bus0.layer_reset) lr++;
      if (bus0.done || cyc >= 5000) break;
      if (poke && cyc == 5) begin
        bus0.start      = 1'b1;
        bus0.iter_limit = ITER_W'(1);
      end else begin
        bus0.start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    bus0.start = 1'b0;

    // reference model
    foreach (cnt[i]) cnt[i] = 0;
    n_it = 0; exp_cyc = 1; t1 = 0; t2 = 0; win = 0; es_hit = 0;
    stopped = (limit == 0);
    while (limit > 0 && n_it < samp_q.size()) begin
      s = samp_q[n_it];
      for (int i = 0; i < OUT_DIM; i++) if (s[i] && cnt[i] < CMAX) cnt[i]++;
      exp_cyc += 2 + wait_q[n_it] + OUT_DIM;
      n_it++;
      win = 0;
      for (int i = 1; i < OUT_DIM; i++) if (cnt[i] > cnt[win]) win = i;
      t1 = cnt[win];
      t2 = 0;
      for (int i = 0; i < OUT_DIM; i++) if (i != win && cnt[i] > t2) t2 = cnt[i];
      if (n_it == limit) begin stopped = 1; break; end
      if (es && (t1 - t2) >= mg && t1 > 0) begin stopped = 1; es_hit = 1; break; end
    end

    check({tag, "_done"}, bus0.done, 1);
    check({tag, "_busy"}, bus0.busy, 0);
    check({tag, "_state"}, state0, ST_DONE);
    check({tag, "_model_stop_reached"}, stopped, 1);
    check({tag, "_samples_used"}, samp_q.size(), n_it);
    check({tag, "_launch_pulses"}, lr, n_it);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_iter_count"}, bus0.iter_count, n_it);
    check({tag, "_winner"}, bus0.winner, win);
    check({tag, "_winner_valid"}, bus0.winner_valid, (t1 > 0));
    check({tag, "_early_stopped"}, bus0.early_stopped, es_hit);
    for (int i = 0; i < OUT_DIM; i++) exp_q.push_back(CNT_W'(cnt[i]));
    for (int i = 0; i < OUT_DIM; i++)
      check({tag, "_count", $sformatf("%0d", i)}, bus0.vote_count[i*CNT_W +: CNT_W], exp_q.pop_front());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    reset = 1'b1;
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.iter_limit = '0;
    bus0.margin = '0; bus0.early_stop_en = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.iter_limit = '0;
    bus1.margin = '0; bus1.early_stop_en = 1'b0;
    bus1.layer_done = 1'b1;        // chain of dut1 always claims a sample
    bus1.layer_sample = '1;

    // reset state
    #12;
    check_reset_state("rst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_layer_reset", bus0.layer_reset, 0);
    check("rst_release_state", state0, ST_IDLE);
    check("idle_layer_done_ignored", bus1.vote_count, 0);

    // fixed class 3, no early stop
    pat = OUT_DIM'(1 << 3);
    run0(5, 0, 0, 0, 0, "fix3");
    check("fix3_iters_const", bus0.iter_count, 5);

    // early stop on margin 3 with class 7 every pass
    pat = OUT_DIM'(1 << 7);
    run0(100, 3, 1, 0, 0, "es7");
    check("es7_iters_const", bus0.iter_count, 3);

    // zero iteration limit: done next cycle, no launch
    run0(0, 0, 0, 0, 0, "lim0");

    // margin 0: stop after the first pass with any vote (first pass empty)
    pat = OUT_DIM'(1 << 5);
    run0(10, 0, 1, 2, 0, "m0");
    check("m0_iters_const", bus0.iter_count, 2);

    // start while busy is ignored
    pat = OUT_DIM'(10'b0000110001);
    run0(4, 0, 0, 0, 1, "busy_start");

    // randomized runs
    for (int k = 0; k < 8; k++)
      run0($urandom_range(1, 8), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1, 0,
           $sformatf("rand%0d", k));

    // abort during the wait of the second iteration
    fixed_d = 6;
    pat = OUT_DIM'(1);
    mode = 0;
    @(negedge clock);
    bus0.iter_limit = ITER_W'(5); bus0.early_stop_en = 1'b0; bus0.start = 1'b1;
    @(negedge clock);
    bus0.start = 1'b0;
    cyc = 0;
    while (!(state0 == ST_WAIT && bus0.iter_count == 1) && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    check("abort_reach_wait2", (state0 == ST_WAIT) && (bus0.iter_count == 1), 1);
    bus0.abort = 1'b1;
    @(negedge clock);
    bus0.abort = 1'b0;
    check("abort_state", state0, ST_IDLE);
    check("abort_busy", bus0.busy, 0);
    check("abort_done", bus0.done, 0);
    check("abort_layer_reset", bus0.layer_reset, 1);
    check("abort_iter_kept", bus0.iter_count, 1);
    check("abort_count0_kept", bus0.vote_count[CNT_W-1:0], 1);
    @(negedge clock);
    check("abort_layer_reset_drop", bus0.layer_reset, 0);
    repeat (10) @(negedge clock);
    check("abort_late_sample_ignored", bus0.iter_count, 1);
    check("abort_state_held", state0, ST_IDLE);
    fixed_d = 0;
    pat = OUT_DIM'(10'b1000000010);
    run0(3, 0, 0, 0, 0, "post_abort");

    // saturating counters on the narrow instance, all classes tie
    @(negedge clock);
    bus1.iter_limit = ITER_W'(6); bus1.start = 1'b1;
    @(negedge clock);
    bus1.start = 1'b0;
    cyc = 1;
    while (!bus1.done && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    check("sat_done", bus1.done, 1);
    check("sat_state", state1, ST_DONE);
    check("sat_cycles", cyc, 1 + 6 * (2 + 1 + OUT_DIM));
    check("sat_winner", bus1.winner, 0);
    check("sat_winner_valid", bus1.winner_valid, 1);
    check("sat_iter_count", bus1.iter_count, 6);
    check("sat_early_stopped", bus1.early_stopped, 0);
    for (int i = 0; i < OUT_DIM; i++) exp_q.push_back(CNT_W'(3));
    for (int i = 0; i < OUT_DIM; i++)
      check($sformatf("sat_count%0d", i), bus1.vote_count[i*2 +: 2], exp_q.pop_front());

    // reset asserted in the middle of a scan
    pat = OUT_DIM'(1 << 2);
    mode = 0;
    @(negedge clock);
    bus0.iter_limit = ITER_W'(3); bus0.start = 1'b1;
    @(negedge clock);
    bus0.start = 1'b0;
    cyc = 0;
    while (state0 != ST_SCAN && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    check("scan_reached", state0, ST_SCAN);
    #2 reset = 1'b1;
    #1 check_reset_state("mid_scan_rst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_scan_release_layer_reset", bus0.layer_reset, 0);
    check("mid_scan_release_state", state0, ST_IDLE);
    pat = '1;
    kick = 1'b1;
    repeat (2) @(negedge clock);
    kick = 1'b0;
    repeat (8) @(negedge clock);
    check("idle_pulse_counts", bus0.vote_count, 0);
    check("idle_pulse_iters", bus0.iter_count, 0);
    check("idle_pulse_state", state0, ST_IDLE);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
